// File: rtl/ex_stage_md_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_md_if
// Description : ID/EX -> EX/MEM bundle for the execute stage. The master side
//               is the pipeline (drives id_* and pipeline control); the slave
//               side is ex_stage_md.
// Revision    : 1.0  initial release
// ============================================================================
interface ex_stage_md_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 30
);
  // ID/EX side
  logic [PC_W-1:0]   id_pc;
  logic              id_en;
  logic [3:0]        id_alu_op;
  logic [DATA_W-1:0] id_alu_in_0;
  logic [DATA_W-1:0] id_alu_in_1;
  logic              id_br_flag;
  logic              id_gpr_we_;
  logic [1:0]        id_mem_op;
  logic [1:0]        id_ctrl_op;
  logic [4:0]        id_dst_addr;
  logic [2:0]        id_exp_code;
  logic [DATA_W-1:0] id_mem_wr_data;
  // pipeline control
  logic              stall;
  logic              flush;
  logic              int_detect;
  // combinational outputs
  logic [DATA_W-1:0] fwd_data;
  logic              ex_busy;
  // EX/MEM register
  logic [PC_W-1:0]   ex_pc;
  logic              ex_en;
  logic              ex_br_flag;
  logic [1:0]        ex_mem_op;
  logic [DATA_W-1:0] ex_mem_wr_data;
  logic [1:0]        ex_ctrl_op;
  logic [4:0]        ex_dst_addr;
  logic              ex_gpr_we_;
  logic [2:0]        ex_exp_code;
  logic [DATA_W-1:0] ex_out;

  modport master (
    output id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
           id_gpr_we_, id_mem_op, id_ctrl_op, id_dst_addr, id_exp_code,
           id_mem_wr_data, stall, flush, int_detect,
    input  fwd_data, ex_busy, ex_pc, ex_en, ex_br_flag, ex_mem_op,
           ex_mem_wr_data, ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code,
           ex_out
  );

  modport slave (
    input  id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
           id_gpr_we_, id_mem_op, id_ctrl_op, id_dst_addr, id_exp_code,
           id_mem_wr_data, stall, flush, int_detect,
    output fwd_data, ex_busy, ex_pc, ex_en, ex_br_flag, ex_mem_op,
           ex_mem_wr_data, ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code,
           ex_out
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage_md.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_md
// Description : Execute stage. Single-cycle ALU, iterative unsigned
//               multiply (shift-add) / divide (restoring) unit taking
//               DATA_W+1 busy cycles, and the EX/MEM pipeline register with
//               stall / flush / interrupt handling.
// Revision    : 1.0  initial release
// ============================================================================
module ex_stage_md #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 30,
  parameter bit MD_EN  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  ex_stage_md_if.slave bus
);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = (SH_W > 5) ? SH_W : 5;

  localparam logic [3:0] OP_ADDS  = 4'd1;
  localparam logic [3:0] OP_ADDU  = 4'd2;
  localparam logic [3:0] OP_SUBS  = 4'd3;
  localparam logic [3:0] OP_SUBU  = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SHRL  = 4'd8;
  localparam logic [3:0] OP_SHLL  = 4'd9;
  localparam logic [3:0] OP_MULU  = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_REMU  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   b_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;

  logic [DATA_W-1:0]   a, b;
  logic [SH_W-1:0]     shamt;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_ovf;
  logic                is_md, abort, launch, busy;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     rem_sh, rem_sub;
  logic                rem_ge;
  logic [DATA_W-1:0]   md_res;
  logic [DATA_W-1:0]   res;
  logic [2:0]          exp_code;

  assign a      = bus.id_alu_in_0;
  assign b      = bus.id_alu_in_1;
  assign shamt  = b[SH_W-1:0];
  assign is_md  = (bus.id_alu_op >= OP_MULU) && (bus.id_alu_op <= OP_REMU);
  // stall outranks flush/interrupt: an abort only happens on a non-stalled edge
  assign abort  = (bus.flush | bus.int_detect) & ~bus.stall;
  assign launch = (state_q == ST_IDLE) & bus.id_en & is_md & MD_EN &
                  ~bus.stall & ~bus.flush & ~bus.int_detect;
  assign busy   = launch | (state_q == ST_BUSY);

  assign bus.ex_busy  = busy;
  assign bus.fwd_data = res;

  // Single-cycle ALU with signed-overflow detection for ADDS/SUBS
  always_comb begin
    alu_res = a;
    alu_ovf = 1'b0;
    case (bus.id_alu_op)
      OP_ADDS: begin
        alu_res = a + b;
        alu_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (alu_res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_ADDU: alu_res = a + b;
      OP_SUBS: begin
        alu_res = a - b;
        alu_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (alu_res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUBU: alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHRL: alu_res = a >> shamt;
      OP_SHLL: alu_res = a << shamt;
      default: alu_res = a;
    endcase
  end

  // One multiply step adds the multiplicand when the product LSB is set; one
  // divide step trial-subtracts the divisor from the shifted remainder. The
  // borrow bit of the trial subtraction decides the quotient bit. A zero
  // divisor never borrows, giving all-ones quotient and remainder = dividend.
  assign mul_sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + {1'b0, b_q & {DATA_W{prod_q[0]}}};
  assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign rem_ge  = ~rem_sub[DATA_W];

  // MUL/DIV datapath: operands latched at launch, one iteration per BUSY cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      b_q    <= '0;
      prod_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else if (launch) begin
      op_q   <= bus.id_alu_op;
      b_q    <= b;
      prod_q <= {{DATA_W{1'b0}}, a};
      rem_q  <= '0;
      quo_q  <= a;
    end else if (state_q == ST_BUSY) begin
      prod_q <= {mul_sum, prod_q[DATA_W-1:1]};
      rem_q  <= rem_ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
      quo_q  <= {quo_q[DATA_W-2:0], rem_ge};
    end
  end

  // Pick the finished MUL/DIV result according to the latched op
  always_comb begin
    md_res = quo_q;
    case (op_q)
      OP_MULU:  md_res = prod_q[DATA_W-1:0];
      OP_MULHU: md_res = prod_q[2*DATA_W-1:DATA_W];
      OP_REMU:  md_res = rem_q;
      default:  md_res = quo_q;
    endcase
  end

  // Result and exception code that the EX/MEM register would load
  always_comb begin
    res      = alu_res;
    exp_code = bus.id_exp_code;
    if (is_md) begin
      res = MD_EN ? md_res : '0;
      if (!MD_EN) exp_code = 3'h2;
    end else if (bus.id_en && alu_ovf) begin
      exp_code = 3'h3;
    end
  end

  // MUL/DIV sequencer next-state: IDLE -> BUSY (DATA_W iterations) -> DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(DATA_W - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: begin
        if (!bus.stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX/MEM register: stall holds, flush/interrupt/busy insert a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ex_pc          <= '0;
      bus.ex_en          <= 1'b0;
      bus.ex_br_flag     <= 1'b0;
      bus.ex_mem_op      <= '0;
      bus.ex_mem_wr_data <= '0;
      bus.ex_ctrl_op     <= '0;
      bus.ex_dst_addr    <= '0;
      bus.ex_gpr_we_     <= 1'b1;
      bus.ex_exp_code    <= '0;
      bus.ex_out         <= '0;
    end else if (!bus.stall) begin
      if (bus.flush || bus.int_detect || busy) begin
        bus.ex_pc          <= '0;
        bus.ex_en          <= 1'b0;
        bus.ex_br_flag     <= 1'b0;
        bus.ex_mem_op      <= '0;
        bus.ex_mem_wr_data <= '0;
        bus.ex_ctrl_op     <= '0;
        bus.ex_dst_addr    <= '0;
        bus.ex_gpr_we_     <= 1'b1;
        bus.ex_exp_code    <= '0;
        bus.ex_out         <= '0;
      end else begin
        bus.ex_pc          <= bus.id_pc;
        bus.ex_en          <= bus.id_en;
        bus.ex_br_flag     <= bus.id_br_flag;
        bus.ex_mem_op      <= bus.id_mem_op;
        bus.ex_mem_wr_data <= bus.id_mem_wr_data;
        bus.ex_ctrl_op     <= bus.id_ctrl_op;
        bus.ex_dst_addr    <= bus.id_dst_addr;
        bus.ex_gpr_we_     <= bus.id_gpr_we_;
        bus.ex_exp_code    <= exp_code;
        bus.ex_out         <= res;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ex_stage_md.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage_md
// Description : Self-checking bench for ex_stage_md. A transaction-level
//               model tracks when a MUL/DIV was launched and what the EX/MEM
//               register must hold; directed cases pin literal results.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ex_stage_md;
  localparam int DW = 32;
  localparam int PW = 30;

  localparam logic [3:0] OP_ADDS  = 4'd1;
  localparam logic [3:0] OP_ADDU  = 4'd2;
  localparam logic [3:0] OP_MULU  = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_md_if #(.DATA_W(DW), .PC_W(PW)) bus ();
  ex_stage_md_if #(.DATA_W(DW), .PC_W(PW)) bus0 ();

  ex_stage_md #(.DATA_W(DW), .PC_W(PW), .MD_EN(1'b1)) u_dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );
  ex_stage_md #(.DATA_W(DW), .PC_W(PW), .MD_EN(1'b0)) u_dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic bit is_md_op(input logic [3:0] op);
    return (op >= 4'd10) && (op <= 4'd13);
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint unsigned ua, ub, p;
    logic [63:0] pv;
    ua = a; ub = b; p = ua * ub; pv = p;
    case (op)
      4'd0:       return a;
      4'd1, 4'd2: return a + b;
      4'd3, 4'd4: return a - b;
      4'd5:       return a & b;
      4'd6:       return a | b;
      4'd7:       return a ^ b;
      4'd8:       return a >> b[4:0];
      4'd9:       return a << b[4:0];
      4'd10:      return pv[31:0];
      4'd11:      return pv[63:32];
      4'd12:      return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13:      return (b == 0) ? a : a % b;
      default:    return a;
    endcase
  endfunction

  function automatic bit ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    sa = $signed(a); sb = $signed(b);
    if (op == 4'd1)      s = sa + sb;
    else if (op == 4'd3) s = sa - sb;
    else                 return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // ---------------- model of the EX/MEM register ----------------
  logic [PW-1:0] m_pc;
  logic          m_en, m_br, m_we;
  logic [1:0]    m_mem_op, m_ctrl;
  logic [4:0]    m_dst;
  logic [2:0]    m_exp;
  logic [31:0]   m_wr, m_out;
  bit            md_active = 1'b0;
  int            md_launch = 0;
  int            cyc       = 0;
  bit            consumed  = 1'b1;

  task automatic model_bubble();
    m_pc = '0; m_en = 1'b0; m_br = 1'b0; m_we = 1'b1; m_mem_op = '0; m_ctrl = '0;
    m_dst = '0; m_exp = '0; m_wr = '0; m_out = '0;
  endtask

  // Compare every cycle on the falling edge, then advance the model to what
  // the next rising edge must produce.
  always @(negedge clk) begin
    bit in_busy, launch_now, exp_busy, md;
    if (!rst_n) begin
      model_bubble();
      md_active = 1'b0;
    end
    md         = is_md_op(bus.id_alu_op);
    in_busy    = md_active && (cyc <= md_launch + DW);
    launch_now = !md_active && bus.id_en && md && !bus.stall && !bus.flush && !bus.int_detect;
    exp_busy   = launch_now || in_busy;

    chk("ex_busy",        bus.ex_busy,        exp_busy);
    chk("ex_out",         bus.ex_out,         m_out);
    chk("ex_en",          bus.ex_en,          m_en);
    chk("ex_pc",          bus.ex_pc,          m_pc);
    chk("ex_gpr_we_",     bus.ex_gpr_we_,     m_we);
    chk("ex_exp_code",    bus.ex_exp_code,    m_exp);
    chk("ex_br_flag",     bus.ex_br_flag,     m_br);
    chk("ex_mem_op",      bus.ex_mem_op,      m_mem_op);
    chk("ex_ctrl_op",     bus.ex_ctrl_op,     m_ctrl);
    chk("ex_dst_addr",    bus.ex_dst_addr,    m_dst);
    chk("ex_mem_wr_data", bus.ex_mem_wr_data, m_wr);
    if (!exp_busy && !md)
      chk("fwd_data", bus.fwd_data, ref_result(bus.id_alu_op, bus.id_alu_in_0, bus.id_alu_in_1));

    if (!rst_n) begin
      consumed = 1'b1;
    end else if (bus.stall) begin
      consumed = 1'b0;
    end else if (bus.flush || bus.int_detect) begin
      model_bubble();
      md_active = 1'b0;
      consumed  = 1'b1;
    end else if (exp_busy) begin
      model_bubble();
      if (launch_now) begin
        md_active = 1'b1;
        md_launch = cyc;
      end
      consumed = 1'b0;
    end else begin
      m_pc     = bus.id_pc;
      m_en     = bus.id_en;
      m_br     = bus.id_br_flag;
      m_we     = bus.id_gpr_we_;
      m_mem_op = bus.id_mem_op;
      m_ctrl   = bus.id_ctrl_op;
      m_dst    = bus.id_dst_addr;
      m_wr     = bus.id_mem_wr_data;
      m_out    = ref_result(bus.id_alu_op, bus.id_alu_in_0, bus.id_alu_in_1);
      m_exp    = (bus.id_en && ref_ovf(bus.id_alu_op, bus.id_alu_in_0, bus.id_alu_in_1))
                 ? 3'h3 : bus.id_exp_code;
      md_active = 1'b0;
      consumed  = 1'b1;
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_en = 1'b0; bus.id_alu_op = 4'd0; bus.id_alu_in_0 = '0; bus.id_alu_in_1 = '0;
    bus.id_pc = '0; bus.id_br_flag = 1'b0; bus.id_gpr_we_ = 1'b1; bus.id_mem_op = '0;
    bus.id_ctrl_op = '0; bus.id_dst_addr = '0; bus.id_exp_code = '0; bus.id_mem_wr_data = '0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.int_detect = 1'b0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] code);
    bus.id_en = 1'b1; bus.id_alu_op = op; bus.id_alu_in_0 = a; bus.id_alu_in_1 = b;
    bus.id_exp_code = code; bus.id_pc = PW'($urandom); bus.id_dst_addr = 5'($urandom);
    bus.id_gpr_we_ = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.int_detect = 1'b0;
  endtask

  task automatic run_single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] code, input logic [31:0] exp_out,
                            input logic [2:0] exp_code, input string name);
    set_op(op, a, b, code);
    step();
    chk({name, "_out"},  bus.ex_out,      exp_out);
    chk({name, "_code"}, bus.ex_exp_code, exp_code);
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input string name);
    int n;
    n = 0;
    set_op(op, a, b, 3'h0);
    #1;
    while (bus.ex_busy && n < 200) begin
      n++;
      step();
      if (n == 2) chk({name, "_bubble_en"}, bus.ex_en, 1'b0);
    end
    chk({name, "_busy_cycles"}, n, DW + 1);
    step();
    chk({name, "_out"}, bus.ex_out, exp_out);
    chk({name, "_en"},  bus.ex_en,  1'b1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    idle_inputs();
    bus0.id_en = 1'b0; bus0.id_alu_op = 4'd0; bus0.id_alu_in_0 = '0; bus0.id_alu_in_1 = '0;
    bus0.id_pc = '0; bus0.id_br_flag = 1'b0; bus0.id_gpr_we_ = 1'b1; bus0.id_mem_op = '0;
    bus0.id_ctrl_op = '0; bus0.id_dst_addr = '0; bus0.id_exp_code = '0;
    bus0.id_mem_wr_data = '0; bus0.stall = 1'b0; bus0.flush = 1'b0; bus0.int_detect = 1'b0;

    // reset values
    repeat (3) step();
    chk("rst_gpr_we_", bus.ex_gpr_we_, 1'b1);
    chk("rst_en",      bus.ex_en,      1'b0);
    chk("rst_out",     bus.ex_out,     32'h0);
    chk("rst_busy",    bus.ex_busy,    1'b0);
    rst_n = 1'b1;
    step();

    // signed overflow and its unsigned twin
    run_single(OP_ADDS, 32'h7FFF_FFFF, 32'h1, 3'h5, 32'h8000_0000, 3'h3, "adds_ovf");
    run_single(OP_ADDU, 32'h7FFF_FFFF, 32'h1, 3'h5, 32'h8000_0000, 3'h5, "addu_noovf");

    // back-to-back multiplies, then divides including divide-by-zero
    run_md(OP_MULU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "mulu");
    run_md(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "mulhu");
    run_md(OP_DIVU,  32'd100,       32'd7,         32'd14,        "divu");
    run_md(OP_REMU,  32'd100,       32'd7,         32'd2,         "remu");
    run_md(OP_DIVU,  32'hDEAD_BEEF, 32'd0,         32'hFFFF_FFFF, "divu_by0");
    run_md(OP_REMU,  32'd9,         32'd0,         32'd9,         "remu_by0");

    // flush at busy iteration 10, then a normal op
    set_op(OP_MULU, 32'd123, 32'd456, 3'h0);
    repeat (10) step();
    bus.flush = 1'b1;
    step();
    idle_inputs();
    #1;
    chk("flush_busy", bus.ex_busy, 1'b0);
    chk("flush_en",   bus.ex_en,   1'b0);
    step();
    run_single(OP_ADDU, 32'd5, 32'd6, 3'h1, 32'd11, 3'h1, "addu_after_flush");

    // stall held three cycles in DONE
    set_op(OP_DIVU, 32'd1000, 32'd10, 3'h0);
    #1;
    n = 0;
    while (bus.ex_busy && n < 200) begin
      n++;
      step();
    end
    chk("stall_busy_cycles", n, DW + 1);
    bus.stall = 1'b1;
    repeat (3) begin
      step();
      chk("stall_hold_out",  bus.ex_out,  32'h0);
      chk("stall_hold_en",   bus.ex_en,   1'b0);
      chk("stall_hold_busy", bus.ex_busy, 1'b0);
    end
    bus.stall = 1'b0;
    step();
    chk("divu_after_stall", bus.ex_out, 32'd100);
    idle_inputs();

    // MUL/DIV absent: undefined-instruction code in one cycle, never busy
    bus0.id_en = 1'b1; bus0.id_alu_op = OP_MULU; bus0.id_alu_in_0 = 32'd3;
    bus0.id_alu_in_1 = 32'd4; bus0.id_exp_code = 3'h1;
    #1;
    chk("mden0_busy", bus0.ex_busy, 1'b0);
    step();
    chk("mden0_code", bus0.ex_exp_code, 3'h2);
    chk("mden0_out",  bus0.ex_out,      32'h0);
    chk("mden0_en",   bus0.ex_en,       1'b1);
    chk("mden0_busy2", bus0.ex_busy,    1'b0);
    bus0.id_en = 1'b0; bus0.id_alu_op = 4'd0;

    // asynchronous reset in the middle of a multiply
    set_op(OP_MULU, 32'd7, 32'd9, 3'h0);
    repeat (5) step();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("mid_rst_gpr_we_", bus.ex_gpr_we_, 1'b1);
    chk("mid_rst_en",      bus.ex_en,      1'b0);
    chk("mid_rst_out",     bus.ex_out,     32'h0);
    chk("mid_rst_busy",    bus.ex_busy,    1'b0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", bus.ex_busy, 1'b0);
    run_md(OP_MULU, 32'd7, 32'd9, 32'd63, "mul_after_reset");

    // randomized traffic; id_* only changes once the instruction is consumed
    for (int i = 0; i < 2500; i++) begin
      if (consumed) begin
        if ($urandom_range(0, 3) == 0) rop = 4'(10 + $urandom_range(0, 3));
        else                           rop = 4'($urandom_range(0, 15));
        ra = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : 32'($urandom);
        case ($urandom_range(0, 3))
          0:       rb = 32'h0;
          1:       rb = 32'($urandom_range(1, 20));
          default: rb = 32'($urandom);
        endcase
        bus.id_alu_op      = rop;
        bus.id_alu_in_0    = ra;
        bus.id_alu_in_1    = rb;
        bus.id_en          = is_md_op(rop) ? 1'b1 : ($urandom_range(0, 9) != 0);
        bus.id_pc          = PW'($urandom);
        bus.id_br_flag     = 1'($urandom);
        bus.id_gpr_we_     = 1'($urandom);
        bus.id_mem_op      = 2'($urandom);
        bus.id_ctrl_op     = 2'($urandom);
        bus.id_dst_addr    = 5'($urandom);
        bus.id_exp_code    = 3'($urandom);
        bus.id_mem_wr_data = 32'($urandom);
      end
      bus.stall      = ($urandom_range(0, 99) < 12);
      bus.flush      = ($urandom_range(0, 99) < 3);
      bus.int_detect = ($urandom_range(0, 99) < 2);
      step();
    end
    idle_inputs();
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // absolute time bound
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
